// File: rtl/axi_master_full.sv
// Command-driven AXI4 master: splits byte-granular write/read commands into
// INCR/FIXED bursts (max-beats and 4 KB limited), one outstanding burst per direction.
//   state   | meaning
//   IDLE    | ready for a command
//   AW / AR | address phase of the current burst
//   W / R   | data beats of the current burst
//   B       | waiting for write response
//   DONE    | one-cycle completion pulse, sticky error reported and cleared
module axi_master_full #(
  parameter int AXI_ADDR_WIDTH             = 32,
  parameter int AXI_DATA_WIDTH             = 32,
  parameter int USER_TRANSACTION_SIZE_BITS = 24,
  parameter int USER_DATA_WIDTH            = 32,
  parameter int AXI_MAX_BEATS              = 256
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]             cmd_wr_addr,
  input  logic [USER_TRANSACTION_SIZE_BITS-1:0] cmd_wr_size,
  input  logic                                  cmd_wr_low_lat,
  input  logic                                  cmd_wr_valid,
  output logic                                  cmd_wr_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]             cmd_rd_addr,
  input  logic [USER_TRANSACTION_SIZE_BITS-1:0] cmd_rd_size,
  input  logic                                  cmd_rd_low_lat,
  input  logic                                  cmd_rd_valid,
  output logic                                  cmd_rd_ready,
  input  logic [USER_DATA_WIDTH-1:0]            wr_data,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  output logic [USER_DATA_WIDTH-1:0]            rd_data,
  output logic                                  rd_last,
  output logic                                  rd_valid,
  input  logic                                  rd_ready,
  output logic                                  wr_done,
  output logic                                  wr_error,
  output logic                                  rd_done,
  output logic                                  rd_error,
  output logic [AXI_ADDR_WIDTH-1:0]             m_axi_aw_addr,
  output logic [7:0]                            m_axi_aw_len,
  output logic [2:0]                            m_axi_aw_size,
  output logic [1:0]                            m_axi_aw_burst,
  output logic                                  m_axi_aw_lock,
  output logic [3:0]                            m_axi_aw_cache,
  output logic [2:0]                            m_axi_aw_prot,
  output logic                                  m_axi_aw_valid,
  input  logic                                  m_axi_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]             m_axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]           m_axi_w_strb,
  output logic                                  m_axi_w_last,
  output logic                                  m_axi_w_valid,
  input  logic                                  m_axi_w_ready,
  input  logic [1:0]                            m_axi_b_resp,
  input  logic                                  m_axi_b_valid,
  output logic                                  m_axi_b_ready,
  output logic [AXI_ADDR_WIDTH-1:0]             m_axi_ar_addr,
  output logic [7:0]                            m_axi_ar_len,
  output logic [2:0]                            m_axi_ar_size,
  output logic [1:0]                            m_axi_ar_burst,
  output logic                                  m_axi_ar_lock,
  output logic [3:0]                            m_axi_ar_cache,
  output logic [2:0]                            m_axi_ar_prot,
  output logic                                  m_axi_ar_valid,
  input  logic                                  m_axi_ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0]             m_axi_r_data,
  input  logic [1:0]                            m_axi_r_resp,
  input  logic                                  m_axi_r_last,
  input  logic                                  m_axi_r_valid,
  output logic                                  m_axi_r_ready
);
  localparam int B     = AXI_DATA_WIDTH / 8;
  localparam int LOG_B = $clog2(B);
  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int SW    = USER_TRANSACTION_SIZE_BITS + 2;
  localparam logic [AW-1:0] ADDR_LOW  = AW'(B - 1);
  localparam logic [B-1:0]  STRB_ONES = '1;

  localparam logic [2:0] WR_IDLE = 3'd0, WR_AW = 3'd1, WR_W = 3'd2, WR_B = 3'd3, WR_DONE = 3'd4;
  localparam logic [1:0] RD_IDLE = 2'd0, RD_AR = 2'd1, RD_R = 2'd2, RD_DONE = 2'd3;

  if (USER_DATA_WIDTH != AXI_DATA_WIDTH) begin : g_width_check
    $error("user data width must equal AXI data width");
  end

  // Beats for the next burst: limited by remaining beats, max burst and the 4 KB page end.
  function automatic logic [8:0] calc_beats(input logic [11:0] a_lo, input logic [SW-1:0] rem);
    logic [12:0] to4k;
    logic [8:0]  n;
    to4k = (13'h1000 - {1'b0, a_lo}) >> LOG_B;
    n = 9'(AXI_MAX_BEATS);
    if (to4k < {4'd0, n}) n = to4k[8:0];
    if (rem < SW'(n)) n = rem[8:0];
    return n;
  endfunction

  logic unused_ok;
  assign unused_ok = &{1'b0, cmd_wr_low_lat, cmd_rd_low_lat};

  // ---------------- write path ----------------
  logic [2:0]    wr_state;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_len;
  logic [SW-1:0] wr_rem;
  logic [8:0]    wr_cnt;
  logic [B-1:0]  wr_strb_first, wr_strb_last;
  logic          wr_first, wr_err;

  logic [SW-1:0] wr_off, wr_total, wr_end;
  logic [AW-1:0] wr_base, wr_addr_nxt;
  logic [8:0]    wr_beats_new, wr_beats_nxt;

  always_comb begin
    wr_off       = SW'(cmd_wr_addr & ADDR_LOW);
    wr_total     = (wr_off + SW'(cmd_wr_size) + SW'(B - 1)) >> LOG_B;
    wr_end       = (wr_off + SW'(cmd_wr_size) - SW'(1)) & SW'(B - 1);
    wr_base      = cmd_wr_addr & ~ADDR_LOW;
    wr_beats_new = calc_beats(wr_base[11:0], wr_total);
    wr_addr_nxt  = wr_addr + (AW'({1'b0, wr_len} + 9'd1) << LOG_B);
    wr_beats_nxt = calc_beats(wr_addr[11:0], wr_rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state      <= WR_IDLE;
      wr_addr       <= '0;
      wr_len        <= '0;
      wr_rem        <= '0;
      wr_cnt        <= '0;
      wr_strb_first <= '0;
      wr_strb_last  <= '0;
      wr_first      <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: if (cmd_wr_valid) begin
          if (cmd_wr_size == '0) begin
            wr_state <= WR_DONE;
          end else begin
            wr_addr       <= wr_base;
            wr_rem        <= wr_total;
            wr_len        <= 8'(wr_beats_new - 9'd1);
            wr_strb_first <= STRB_ONES << wr_off;
            wr_strb_last  <= STRB_ONES >> (SW'(B - 1) - wr_end);
            wr_first      <= 1'b1;
            wr_state      <= WR_AW;
          end
        end
        WR_AW: if (m_axi_aw_ready) begin
          wr_cnt   <= {1'b0, wr_len} + 9'd1;
          wr_state <= WR_W;
        end
        WR_W: if (wr_valid && m_axi_w_ready) begin
          wr_cnt   <= wr_cnt - 9'd1;
          wr_rem   <= wr_rem - SW'(1);
          wr_first <= 1'b0;
          if (wr_cnt == 9'd1) begin
            wr_addr  <= wr_addr_nxt;
            wr_state <= WR_B;
          end
        end
        WR_B: if (m_axi_b_valid) begin
          if (m_axi_b_resp != 2'b00) wr_err <= 1'b1;
          if (wr_rem == '0) begin
            wr_state <= WR_DONE;
          end else begin
            wr_len   <= 8'(wr_beats_nxt - 9'd1);
            wr_state <= WR_AW;
          end
        end
        WR_DONE: begin
          wr_err   <= 1'b0;
          wr_state <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    m_axi_w_strb = '1;
    if (wr_first) m_axi_w_strb &= wr_strb_first;
    if (wr_rem == SW'(1)) m_axi_w_strb &= wr_strb_last;
  end

  assign cmd_wr_ready   = rst_n && (wr_state == WR_IDLE);
  assign m_axi_aw_addr  = wr_addr;
  assign m_axi_aw_len   = wr_len;
  assign m_axi_aw_size  = 3'(LOG_B);
  assign m_axi_aw_burst = (wr_len == 8'd0) ? 2'b00 : 2'b01;
  assign m_axi_aw_lock  = 1'b0;
  assign m_axi_aw_cache = 4'b0011;
  assign m_axi_aw_prot  = 3'b000;
  assign m_axi_aw_valid = (wr_state == WR_AW);
  assign m_axi_w_data   = wr_data;
  assign m_axi_w_valid  = (wr_state == WR_W) && wr_valid;
  assign m_axi_w_last   = (wr_state == WR_W) && (wr_cnt == 9'd1);
  assign wr_ready       = (wr_state == WR_W) && m_axi_w_ready;
  assign m_axi_b_ready  = (wr_state == WR_B);
  assign wr_done        = (wr_state == WR_DONE);
  assign wr_error       = (wr_state == WR_DONE) && wr_err;

  // ---------------- read path ----------------
  // rd_rem counts beats not yet requested, so zero marks the final burst.
  logic [1:0]    rd_state;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_len;
  logic [SW-1:0] rd_rem;
  logic          rd_err;

  logic [SW-1:0] rd_off, rd_total;
  logic [AW-1:0] rd_base, rd_addr_nxt;
  logic [8:0]    rd_beats_new, rd_beats_nxt;

  always_comb begin
    rd_off       = SW'(cmd_rd_addr & ADDR_LOW);
    rd_total     = (rd_off + SW'(cmd_rd_size) + SW'(B - 1)) >> LOG_B;
    rd_base      = cmd_rd_addr & ~ADDR_LOW;
    rd_beats_new = calc_beats(rd_base[11:0], rd_total);
    rd_addr_nxt  = rd_addr + (AW'({1'b0, rd_len} + 9'd1) << LOG_B);
    rd_beats_nxt = calc_beats(rd_addr_nxt[11:0], rd_rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_rem   <= '0;
      rd_err   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: if (cmd_rd_valid) begin
          if (cmd_rd_size == '0) begin
            rd_state <= RD_DONE;
          end else begin
            rd_addr  <= rd_base;
            rd_len   <= 8'(rd_beats_new - 9'd1);
            rd_rem   <= rd_total - SW'(rd_beats_new);
            rd_state <= RD_AR;
          end
        end
        RD_AR: if (m_axi_ar_ready) rd_state <= RD_R;
        RD_R: if (m_axi_r_valid && rd_ready) begin
          if (m_axi_r_resp != 2'b00) rd_err <= 1'b1;
          if (m_axi_r_last) begin
            if (rd_rem == '0) begin
              rd_state <= RD_DONE;
            end else begin
              rd_addr  <= rd_addr_nxt;
              rd_len   <= 8'(rd_beats_nxt - 9'd1);
              rd_rem   <= rd_rem - SW'(rd_beats_nxt);
              rd_state <= RD_AR;
            end
          end
        end
        default: begin
          rd_err   <= 1'b0;
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  assign cmd_rd_ready   = rst_n && (rd_state == RD_IDLE);
  assign m_axi_ar_addr  = rd_addr;
  assign m_axi_ar_len   = rd_len;
  assign m_axi_ar_size  = 3'(LOG_B);
  assign m_axi_ar_burst = (rd_len == 8'd0) ? 2'b00 : 2'b01;
  assign m_axi_ar_lock  = 1'b0;
  assign m_axi_ar_cache = 4'b0011;
  assign m_axi_ar_prot  = 3'b000;
  assign m_axi_ar_valid = (rd_state == RD_AR);
  assign m_axi_r_ready  = (rd_state == RD_R) && rd_ready;
  assign rd_data        = m_axi_r_data;
  assign rd_valid       = (rd_state == RD_R) && m_axi_r_valid;
  assign rd_last        = (rd_state == RD_R) && m_axi_r_last && (rd_rem == '0);
  assign rd_done        = (rd_state == RD_DONE);
  assign rd_error       = (rd_state == RD_DONE) && rd_err;

endmodule

// File: tb/tb_axi_master_full.sv
// Directed bench for axi_master_full: scoreboard queues hold expected bursts and beats,
// a simple AXI slave model in tasks pops and compares them as the DUT produces traffic.
module tb_axi_master_full;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_wr_addr, cmd_rd_addr;
  logic [23:0] cmd_wr_size, cmd_rd_size;
  logic        cmd_wr_low_lat, cmd_rd_low_lat;
  logic        cmd_wr_valid, cmd_wr_ready, cmd_rd_valid, cmd_rd_ready;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
  logic        wr_done, wr_error, rd_done, rd_error;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_lock, ar_lock;
  logic [3:0]  aw_cache, ar_cache, w_strb;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

  always #5 clk = ~clk;

  axi_master_full dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_wr_addr(cmd_wr_addr), .cmd_wr_size(cmd_wr_size), .cmd_wr_low_lat(cmd_wr_low_lat),
    .cmd_wr_valid(cmd_wr_valid), .cmd_wr_ready(cmd_wr_ready),
    .cmd_rd_addr(cmd_rd_addr), .cmd_rd_size(cmd_rd_size), .cmd_rd_low_lat(cmd_rd_low_lat),
    .cmd_rd_valid(cmd_rd_valid), .cmd_rd_ready(cmd_rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_done(wr_done), .wr_error(wr_error), .rd_done(rd_done), .rd_error(rd_error),
    .m_axi_aw_addr(aw_addr), .m_axi_aw_len(aw_len), .m_axi_aw_size(aw_size),
    .m_axi_aw_burst(aw_burst), .m_axi_aw_lock(aw_lock), .m_axi_aw_cache(aw_cache),
    .m_axi_aw_prot(aw_prot), .m_axi_aw_valid(aw_valid), .m_axi_aw_ready(aw_ready),
    .m_axi_w_data(w_data), .m_axi_w_strb(w_strb), .m_axi_w_last(w_last),
    .m_axi_w_valid(w_valid), .m_axi_w_ready(w_ready),
    .m_axi_b_resp(b_resp), .m_axi_b_valid(b_valid), .m_axi_b_ready(b_ready),
    .m_axi_ar_addr(ar_addr), .m_axi_ar_len(ar_len), .m_axi_ar_size(ar_size),
    .m_axi_ar_burst(ar_burst), .m_axi_ar_lock(ar_lock), .m_axi_ar_cache(ar_cache),
    .m_axi_ar_prot(ar_prot), .m_axi_ar_valid(ar_valid), .m_axi_ar_ready(ar_ready),
    .m_axi_r_data(r_data), .m_axi_r_resp(r_resp), .m_axi_r_last(r_last),
    .m_axi_r_valid(r_valid), .m_axi_r_ready(r_ready)
  );

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [1:0] burst;} ax_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} wb_t;
  typedef struct packed {logic [31:0] data; logic last; logic [1:0] resp;} rb_t;

  ax_t         exp_aw_q[$], exp_ar_q[$];
  wb_t         exp_w_q[$];
  rb_t         r_src_q[$], exp_r_q[$];
  logic [1:0]  b_resp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [23:0] s);
    int t = 0;
    cmd_wr_addr = a; cmd_wr_size = s; cmd_wr_valid = 1'b1; #1;
    while (!cmd_wr_ready && t < 50) begin @(posedge clk); #2; t++; end
    chk("cmd_wr_ready", cmd_wr_ready, 1);
    @(posedge clk); #1; cmd_wr_valid = 1'b0; #1;
  endtask

  task automatic issue_rd(input logic [31:0] a, input logic [23:0] s);
    int t = 0;
    cmd_rd_addr = a; cmd_rd_size = s; cmd_rd_valid = 1'b1; #1;
    while (!cmd_rd_ready && t < 50) begin @(posedge clk); #2; t++; end
    chk("cmd_rd_ready", cmd_rd_ready, 1);
    @(posedge clk); #1; cmd_rd_valid = 1'b0; #1;
  endtask

  task automatic aw_phase();
    ax_t e; int t = 0;
    while (!aw_valid && t < 50) begin @(posedge clk); #2; t++; end
    chk("aw_valid", aw_valid, 1);
    e = exp_aw_q.pop_front();
    chk("aw_addr", aw_addr, e.addr);
    chk("aw_len", aw_len, e.len);
    chk("aw_burst", aw_burst, e.burst);
    chk("aw_size", aw_size, 3'b010);
    chk("aw_attr", {aw_lock, aw_cache, aw_prot}, {1'b0, 4'b0011, 3'b000});
    aw_ready = 1'b1; @(posedge clk); #1; aw_ready = 1'b0;
  endtask

  task automatic w_phase();
    wb_t e; int t; bit last_seen = 1'b0;
    while (!last_seen) begin
      if (exp_w_q.size() == 0) begin
        n_err++; $error("FAIL w_scoreboard: observed empty queue expected beat"); break;
      end
      e = exp_w_q.pop_front();
      wr_data = e.data; wr_valid = 1'b1; w_ready = 1'b1; #1;
      t = 0;
      while (!(w_valid && wr_ready) && t < 50) begin @(posedge clk); #2; t++; end
      chk("w_handshake", w_valid & wr_ready, 1);
      chk("w_data", w_data, e.data);
      chk("w_strb", w_strb, e.strb);
      chk("w_last", w_last, e.last);
      last_seen = e.last;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; w_ready = 1'b0;
  endtask

  task automatic b_phase();
    int t = 0;
    b_resp = b_resp_q.pop_front(); b_valid = 1'b1; #1;
    while (!b_ready && t < 50) begin @(posedge clk); #2; t++; end
    chk("b_ready", b_ready, 1);
    @(posedge clk); #1; b_valid = 1'b0; b_resp = 2'b00;
  endtask

  task automatic service_write(input int nb, input logic exp_err);
    int t = 0;
    for (int i = 0; i < nb; i++) begin aw_phase(); w_phase(); b_phase(); end
    #1;
    while (!wr_done && t < 20) begin @(posedge clk); #2; t++; end
    chk("wr_done", wr_done, 1);
    chk("wr_error", wr_error, exp_err);
    @(posedge clk); #2;
    chk("wr_done_pulse", wr_done, 0);
  endtask

  task automatic ar_phase();
    ax_t e; int t = 0;
    while (!ar_valid && t < 50) begin @(posedge clk); #2; t++; end
    chk("ar_valid", ar_valid, 1);
    e = exp_ar_q.pop_front();
    chk("ar_addr", ar_addr, e.addr);
    chk("ar_len", ar_len, e.len);
    chk("ar_burst", ar_burst, e.burst);
    chk("ar_size", ar_size, 3'b010);
    ar_ready = 1'b1; @(posedge clk); #1; ar_ready = 1'b0;
  endtask

  task automatic r_phase();
    rb_t s, e; int t; bit last_seen = 1'b0;
    while (!last_seen) begin
      if (r_src_q.size() == 0) begin
        n_err++; $error("FAIL r_scoreboard: observed empty queue expected beat"); break;
      end
      s = r_src_q.pop_front();
      e = exp_r_q.pop_front();
      r_data = s.data; r_last = s.last; r_resp = s.resp; r_valid = 1'b1; rd_ready = 1'b1; #1;
      t = 0;
      while (!(rd_valid && r_ready) && t < 50) begin @(posedge clk); #2; t++; end
      chk("r_handshake", rd_valid & r_ready, 1);
      chk("rd_data", rd_data, e.data);
      chk("rd_last", rd_last, e.last);
      last_seen = s.last;
      @(posedge clk); #1;
    end
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; rd_ready = 1'b0;
  endtask

  task automatic service_read(input int nb, input logic exp_err);
    int t = 0;
    for (int i = 0; i < nb; i++) begin ar_phase(); r_phase(); end
    #1;
    while (!rd_done && t < 20) begin @(posedge clk); #2; t++; end
    chk("rd_done", rd_done, 1);
    chk("rd_error", rd_error, exp_err);
    @(posedge clk); #2;
    chk("rd_done_pulse", rd_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cmd_wr_addr = '0; cmd_wr_size = '0; cmd_wr_low_lat = 1'b0; cmd_wr_valid = 1'b0;
    cmd_rd_addr = '0; cmd_rd_size = '0; cmd_rd_low_lat = 1'b1; cmd_rd_valid = 1'b0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_resp = 2'b00; b_valid = 1'b0;
    ar_ready = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0; r_valid = 1'b0;

    // reset state
    repeat (3) @(posedge clk); #2;
    chk("rst_cmd_ready", {cmd_wr_ready, cmd_rd_ready}, 2'b00);
    chk("rst_valids", {aw_valid, w_valid, ar_valid, rd_valid, wr_ready, b_ready, r_ready}, 7'd0);
    chk("rst_done", {wr_done, wr_error, rd_done, rd_error, rd_last, w_last}, 6'd0);
    chk("rst_aw", {aw_addr, aw_len}, 40'd0);
    chk("rst_ar", {ar_addr, ar_len}, 40'd0);
    @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #2;
    chk("idle_cmd_ready", {cmd_wr_ready, cmd_rd_ready}, 2'b11);

    // single-beat write
    exp_aw_q.push_back('{32'h1000, 8'd0, 2'b00});
    exp_w_q.push_back('{32'hABCDEF01, 4'b1111, 1'b1});
    b_resp_q.push_back(2'b00);
    issue_wr(32'h1000, 24'd4);
    chk("aw_valid_after_accept", aw_valid, 1);
    service_write(1, 1'b0);

    // single-beat read
    exp_ar_q.push_back('{32'h2000, 8'd0, 2'b00});
    r_src_q.push_back('{32'h3000, 1'b1, 2'b00});
    exp_r_q.push_back('{32'h3000, 1'b1, 2'b00});
    issue_rd(32'h2000, 24'd4);
    service_read(1, 1'b0);

    // four-beat INCR write
    exp_aw_q.push_back('{32'h3000, 8'd3, 2'b01});
    for (int i = 0; i < 4; i++) exp_w_q.push_back('{32'hA000 + i, 4'b1111, i == 3});
    b_resp_q.push_back(2'b00);
    issue_wr(32'h3000, 24'd16);
    service_write(1, 1'b0);

    // four-beat INCR read
    exp_ar_q.push_back('{32'h4000, 8'd3, 2'b01});
    for (int i = 0; i < 4; i++) begin
      r_src_q.push_back('{32'h5000 + 4 * i, i == 3, 2'b00});
      exp_r_q.push_back('{32'h5000 + 4 * i, i == 3, 2'b00});
    end
    issue_rd(32'h4000, 24'd16);
    service_read(1, 1'b0);

    // write with SLVERR response
    exp_aw_q.push_back('{32'h6000, 8'd1, 2'b01});
    exp_w_q.push_back('{32'h66660000, 4'b1111, 1'b0});
    exp_w_q.push_back('{32'h66660001, 4'b1111, 1'b1});
    b_resp_q.push_back(2'b10);
    issue_wr(32'h6000, 24'd8);
    service_write(1, 1'b1);

    // unaligned write, error flag must have cleared
    exp_aw_q.push_back('{32'h5000, 8'd1, 2'b01});
    exp_w_q.push_back('{32'h11112222, 4'b1100, 1'b0});
    exp_w_q.push_back('{32'h33334444, 4'b0011, 1'b1});
    b_resp_q.push_back(2'b00);
    issue_wr(32'h5002, 24'd4);
    service_write(1, 1'b0);

    // simultaneous commands: one-beat write with both strobe masks, 4 KB-split read with error
    exp_aw_q.push_back('{32'h7000, 8'd0, 2'b00});
    exp_w_q.push_back('{32'h77777777, 4'b0110, 1'b1});
    b_resp_q.push_back(2'b00);
    exp_ar_q.push_back('{32'h0FF8, 8'd1, 2'b01});
    exp_ar_q.push_back('{32'h1000, 8'd1, 2'b01});
    for (int i = 0; i < 4; i++) begin
      r_src_q.push_back('{32'hC000 + i, (i == 1) || (i == 3), (i == 1) ? 2'b10 : 2'b00});
      exp_r_q.push_back('{32'hC000 + i, i == 3, 2'b00});
    end
    cmd_wr_addr = 32'h7001; cmd_wr_size = 24'd2; cmd_wr_valid = 1'b1;
    cmd_rd_addr = 32'h0FF8; cmd_rd_size = 24'd16; cmd_rd_valid = 1'b1; #1;
    chk("dual_cmd_ready", {cmd_wr_ready, cmd_rd_ready}, 2'b11);
    @(posedge clk); #1; cmd_wr_valid = 1'b0; cmd_rd_valid = 1'b0; #1;
    chk("dual_addr_valid", {aw_valid, ar_valid}, 2'b11);
    service_write(1, 1'b0);
    service_read(2, 1'b1);

    // zero-size commands: no AXI traffic, done one cycle after acceptance
    issue_wr(32'hA000, 24'd0);
    chk("wr_size0_done", {wr_done, wr_error, aw_valid}, 3'b100);
    issue_rd(32'hB000, 24'd0);
    chk("rd_size0_done", {rd_done, rd_error, ar_valid}, 3'b100);
    @(posedge clk); #2;
    chk("size0_idle", {wr_done, rd_done, cmd_wr_ready, cmd_rd_ready}, 4'b0011);

    // 257 beats: max-length burst followed by a single FIXED beat
    exp_aw_q.push_back('{32'h8000, 8'd255, 2'b01});
    exp_aw_q.push_back('{32'h8400, 8'd0, 2'b00});
    for (int i = 0; i < 257; i++)
      exp_w_q.push_back('{32'h80000000 + i, (i == 0) ? 4'b1110 : (i == 256) ? 4'b0111 : 4'b1111,
                         (i == 255) || (i == 256)});
    b_resp_q.push_back(2'b00);
    b_resp_q.push_back(2'b00);
    issue_wr(32'h8001, 24'd1026);
    service_write(2, 1'b0);

    // reset in the middle of address phases aborts everything
    issue_wr(32'h9004, 24'd8);
    issue_rd(32'h9000, 24'd32);
    chk("pre_rst_lens", {aw_valid, aw_len, ar_valid, ar_len}, {1'b1, 8'd1, 1'b1, 8'd7});
    rst_n = 1'b0; #1;
    chk("mid_rst_valids", {aw_valid, ar_valid, cmd_wr_ready, cmd_rd_ready}, 4'b0000);
    chk("mid_rst_aw", {aw_addr, aw_len}, 40'd0);
    chk("mid_rst_ar", {ar_addr, ar_len}, 40'd0);
    @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #2;
    chk("post_rst_idle", {cmd_wr_ready, cmd_rd_ready, aw_valid, ar_valid}, 4'b1100);

    exp_aw_q.push_back('{32'h1000, 8'd0, 2'b00});
    exp_w_q.push_back('{32'h12345678, 4'b1111, 1'b1});
    b_resp_q.push_back(2'b00);
    issue_wr(32'h1000, 24'd4);
    service_write(1, 1'b0);

    chk("scoreboard_empty", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_r_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_master_full.md
Name: axi_master_full

Overview:
- Command-driven AXI4 full master: user issues byte-granular write/read commands and streams data words; block splits each command into INCR/FIXED bursts on the AXI4 master interface and reports completion/error per command.
- Sits between user DMA-style logic and an AXI4 interconnect.
- One outstanding burst per direction; write and read paths are independent and may run concurrently.

Parameters:
- AxiAddrWidth_g, 32, AXI address width.
- AxiDataWidth_g, 32, AXI data width (8..1024, power of 2); B = AxiDataWidth_g/8.
- UserTransactionSizeBits_g, 24, width of command byte-size fields.
- UserDataWidth_g, 32, user data width; must equal AxiDataWidth_g (elaboration error otherwise).
- AxiMaxBeats_g, 256, maximum beats per burst (1..256).

Ports:
- Clk in 1: clock, all logic rising-edge.
- Rst in 1: asynchronous, active-low reset.
- CmdWr_Addr/CmdRd_Addr in AxiAddrWidth_g: command start byte address.
- CmdWr_Size/CmdRd_Size in UserTransactionSizeBits_g: command length in bytes.
- CmdWr_LowLat/CmdRd_LowLat in 1: accepted for interface compatibility; no effect.
- CmdWr_Valid/CmdRd_Valid in 1, CmdWr_Ready/CmdRd_Ready out 1: command handshakes.
- Wr_Data in UserDataWidth_g, Wr_Valid in 1, Wr_Ready out 1: write data stream.
- Rd_Data out UserDataWidth_g, Rd_Last out 1, Rd_Valid out 1, Rd_Ready in 1: read data stream.
- Wr_Done, Wr_Error, Rd_Done, Rd_Error out 1: one-cycle completion pulses.
- M_Axi_Aw*, W*, B*, Ar*, R* (AwAddr, AwLen[8], AwSize[3], AwBurst[2], AwLock, AwCache[4], AwProt[3], AwValid/AwReady, WData, WStrb[B], WLast, WValid/WReady, BResp[2], BValid/BReady, Ar* mirror, RData, RResp[2], RLast, RValid/RReady): standard AXI4 master.

Behaviour:
- Reset (Rst=0): all states IDLE; every Valid, Ready, Done, Error, Last output 0; AwAddr/AwLen/ArAddr/ArLen 0. Reset mid-operation aborts all activity immediately.
- Cmd*_Ready = 1 only in IDLE. Command captured on Valid&Ready.
- Per command: offset = Addr mod B; aligned base = Addr with low log2(B) bits cleared; total beats = ceil((offset+Size)/B).
- Size=0: no AXI traffic; Done pulse (Error=0) one cycle after acceptance.
- Burst beats = min(remaining beats, AxiMaxBeats_g, beats to next 4 KB boundary). AxLen = beats-1. AxBurst = 00 (FIXED) when AxLen=0, else 01 (INCR). AxSize = log2(B). AxLock=0, AxCache=0011, AxProt=000.
- Write FSM: IDLE -> AW (AwValid=1 from cycle after acceptance, held until AwReady) -> W -> B -> next burst AW, or DONE -> IDLE.
- W state: WData=Wr_Data, WValid=Wr_Valid, Wr_Ready=WReady (combinational); WLast on final beat of the burst.
- WStrb: all ones, except first beat of command clears lanes below offset, and last beat of command clears lanes above (offset+Size-1) mod B; both apply on a single-beat command. User data is lane-aligned; no byte shifting.
- B state: BReady=1. Any BResp /= 00 sets sticky error flag.
- DONE: Wr_Done=1 and Wr_Error=flag for one cycle; flag cleared.
- Read FSM: IDLE -> AR -> R -> next burst AR, or DONE -> IDLE.
- R state: Rd_Data=RData, Rd_Valid=RValid, RReady=Rd_Ready. Rd_Last=RLast only on the final burst of the command. Any RResp /= 00 sets sticky read error.
- Rd_Done/Rd_Error pulse the cycle after the final beat handshake.
- Address for next burst = previous burst address + beats*B.
- Simultaneous write and read commands are accepted in the same cycle.

Test Plan:
- Write Addr=0x1000 Size=4, Wr_Data=0xABCDEF01 -> AwAddr=0x1000, AwLen=0, AwSize=010, AwBurst=00, WData=0xABCDEF01, WStrb=1111, WLast=1; BResp=00 -> Wr_Done pulse, Wr_Error=0.
- Read Addr=0x2000 Size=4 -> ArAddr=0x2000, ArLen=0, ArBurst=00; slave returns 0x3000 -> Rd_Data=0x3000, Rd_Last=1, Rd_Done, Rd_Error=0.
- Write Addr=0x3000 Size=16, data 0xA000..0xA003 -> AwLen=3, AwBurst=01, four W beats in order, WLast on 4th, Wr_Done.
- Read Addr=0x4000 Size=16 -> ArLen=3, ArBurst=01; Rd_Data=0x5000,0x5004,0x5008,0x500C, Rd_Last on 4th; Rd_Done.
- Write Addr=0x5002 Size=4 -> AwAddr=0x5000, AwLen=1; WStrb=1100 then 0011.
- Read Addr=0x0FF8 Size=16 -> two bursts: ArAddr=0x0FF8 ArLen=1, then ArAddr=0x1000 ArLen=1; BResp/RResp=10 on any beat -> Error=1 with Done.
